// File: rtl/start_screen_ctrl.sv
// Title-screen controller: turns DrawX/DrawY into start_rom lookups, produces a registered
// text pixel, and runs the blink / wait-for-start / launch / play state machine.
module start_screen_ctrl #(
  parameter int         CELL_SHIFT   = 4,
  parameter int         ROM_COLS     = 40,
  parameter int         ROM_ROWS     = 30,
  parameter int         H_ACTIVE     = 640,
  parameter int         V_ACTIVE     = 480,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] START_KEY    = 8'h28
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_tick,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic [7:0]          keycode,
  input  logic                key_valid,
  input  logic                game_over,
  output logic [5:0]          rom_addr,
  input  logic [ROM_COLS-1:0] rom_data,
  output logic                text_on,
  output logic                game_start,
  output logic                title_active
);

  localparam int         CNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM    = 10'(V_ACTIVE);
  localparam logic [9:0] ROWS_LIM = 10'(ROM_ROWS);
  localparam logic [9:0] COLS_LIM = 10'(ROM_COLS);
  localparam logic [5:0] LAST_ROW = 6'(ROM_ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(ROM_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {SHOW, HIDE, LAUNCH, PLAY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             game_start_next;
  logic             start_key;

  logic [9:0] row, col;
  logic [5:0] col_r;
  logic       vis_r;
  logic [5:0] bit_idx;

  assign row       = DrawY >> CELL_SHIFT;
  assign col       = DrawX >> CELL_SHIFT;
  assign start_key = key_valid && (keycode == START_KEY);

  // Column index is forced in-range when the pixel is off the bitmap; vis_r masks the result anyway.
  always_comb begin
    bit_idx = 6'd0;
    if (col_r < LAST_COL + 6'd1)
      bit_idx = LAST_COL - col_r;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= 6'd0;
      col_r    <= 6'd0;
      vis_r    <= 1'b0;
      text_on  <= 1'b0;
    end else begin
      rom_addr <= (row >= ROWS_LIM) ? LAST_ROW : row[5:0];
      col_r    <= col[5:0];
      vis_r    <= (DrawX < H_LIM) && (DrawY < V_LIM) && (row < ROWS_LIM) && (col < COLS_LIM);
      text_on  <= vis_r && rom_data[bit_idx] && ((state == SHOW) || (state == LAUNCH));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= SHOW;
      cnt          <= '0;
      game_start   <= 1'b0;
      title_active <= 1'b1;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      game_start   <= game_start_next;
      title_active <= (state_next != PLAY);
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    game_start_next = 1'b0;
    case (state)
      SHOW, HIDE: begin
        if (start_key) begin
          state_next = LAUNCH;
          cnt_next   = '0;
        end else if (frame_tick && (cnt == CNT_LAST)) begin
          state_next = (state == SHOW) ? HIDE : SHOW;
          cnt_next   = '0;
        end else if (frame_tick) begin
          cnt_next = cnt + 1'b1;
        end
      end
      LAUNCH: begin
        cnt_next = '0;
        if (frame_tick) begin
          state_next      = PLAY;
          game_start_next = 1'b1;
        end
      end
      PLAY: begin
        if (game_over) begin
          state_next = SHOW;
          cnt_next   = '0;
        end
      end
      default: state_next = SHOW;
    endcase
  end

endmodule

// File: tb/tb_start_screen_ctrl.sv
// Randomized bench for start_screen_ctrl: a title-screen reference model predicts every
// cycle's outputs into a queue that a free-running monitor drains and compares.
module tb_start_screen_ctrl;

  localparam int BF = 3;

  logic        Clk, Reset;
  logic        frame_tick, key_valid, game_over;
  logic [9:0]  DrawX, DrawY;
  logic [7:0]  keycode;
  logic [5:0]  rom_addr;
  logic [39:0] rom_data;
  logic        text_on, game_start, title_active;

  logic [39:0] rom [30];
  assign rom_data = (rom_addr < 6'd30) ? rom[rom_addr] : 40'd0;

  start_screen_ctrl #(.BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .DrawX(DrawX), .DrawY(DrawY),
    .keycode(keycode), .key_valid(key_valid), .game_over(game_over), .rom_addr(rom_addr),
    .rom_data(rom_data), .text_on(text_on), .game_start(game_start), .title_active(title_active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0] addr;
    logic       txt;
    logic       gs;
    logic       ta;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   running    = 0;

  // Reference model: title phase (0), launch pending (1), playing (2)
  int         phase;
  bit         lit;
  int         ticks;
  bit         prevVis;
  logic [9:0] prevX, prevY;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    phase   = 0;
    lit     = 1;
    ticks   = 0;
    prevVis = 0;
    prevX   = '0;
    prevY   = '0;
  endtask

  task automatic modelStep(input bit tick, input bit keyOk, input bit gover,
                           input logic [9:0] x, input logic [9:0] y, output exp_t e);
    bit          shown;
    logic [39:0] word;
    int          ry;
    shown = (phase == 0 && lit) || (phase == 1);
    word  = rom[prevY / 16];
    e.txt = prevVis && shown && word[39 - prevX / 16];
    ry    = y / 16;
    e.addr = 6'((ry > 29) ? 29 : ry);
    e.gs  = (phase == 1) && tick;
    case (phase)
      0: begin
        if (keyOk) begin
          phase = 1; ticks = 0; lit = 1;
        end else if (tick) begin
          ticks++;
          if (ticks == BF) begin
            lit = !lit; ticks = 0;
          end
        end
      end
      1: if (tick) phase = 2;
      default: if (gover) begin
        phase = 0; lit = 1; ticks = 0;
      end
    endcase
    e.ta    = (phase != 2);
    prevVis = (x < 640) && (y < 480);
    prevX   = x;
    prevY   = y;
  endtask

  task automatic applyStimulus(input int nCycles);
    exp_t e;
    int   sel;
    for (int i = 0; i < nCycles; i++) begin
      running    = 1;
      frame_tick = ($urandom_range(0, 3) == 0);
      key_valid  = ($urandom_range(0, 9) == 0);
      sel        = $urandom_range(0, 3);
      keycode    = (sel < 2) ? 8'h28 : (sel == 2) ? 8'h1C : 8'($urandom);
      game_over  = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 5))
        0: begin DrawX = 10'd208; DrawY = 10'd208; end
        1: begin DrawX = 10'd0;   DrawY = 10'd208; end
        2: begin DrawX = 10'd700; DrawY = 10'($urandom_range(0, 479)); end
        3: begin DrawX = 10'($urandom_range(0, 639)); DrawY = 10'd490; end
        4: begin DrawX = 10'($urandom); DrawY = 10'($urandom); end
        default: begin DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479)); end
      endcase
      modelStep(frame_tick, key_valid && keycode == 8'h28, game_over, DrawX, DrawY, e);
      expQ.push_back(e);
      @(negedge Clk);
    end
  endtask

  task automatic idleInputs();
    frame_tick = 0; key_valid = 0; game_over = 0; keycode = '0; DrawX = '0; DrawY = '0;
  endtask

  // Asynchronous reset in the middle of a cycle, checked before the next clock edge.
  task automatic doReset();
    running = 0;
    idleInputs();
    #2 Reset = 1;
    #1;
    checkOutput("rst_rom_addr", 8'(rom_addr), 8'h00);
    checkOutput("rst_text_on", 8'(text_on), 8'h00);
    checkOutput("rst_game_start", 8'(game_start), 8'h00);
    checkOutput("rst_title_active", 8'(title_active), 8'h01);
    @(negedge Clk);
    Reset = 0;
    modelReset();
  endtask

  // Monitor: every active edge outside reset presents a new set of outputs.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (running && !Reset) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL queue: got empty required entry at %0t", $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("rom_addr", 8'(rom_addr), 8'(e.addr));
        checkOutput("text_on", 8'(text_on), 8'(e.txt));
        checkOutput("game_start", 8'(game_start), 8'(e.gs));
        checkOutput("title_active", 8'(title_active), 8'(e.ta));
      end
    end
  end

  initial begin
    logic [63:0] w;
    for (int i = 0; i < 30; i++) begin
      w      = {$urandom, $urandom};
      rom[i] = w[39:0];
    end
    rom[13][26] = 1'b1;
    rom[13][39] = 1'b0;

    Reset = 0;
    idleInputs();
    #1 Reset = 1;
    #1;
    checkOutput("init_rom_addr", 8'(rom_addr), 8'h00);
    checkOutput("init_text_on", 8'(text_on), 8'h00);
    checkOutput("init_title_active", 8'(title_active), 8'h01);
    @(negedge Clk);
    Reset = 0;
    modelReset();

    applyStimulus(2000);
    doReset();
    applyStimulus(2000);
    doReset();
    applyStimulus(1000);

    running = 0;
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
